// File: rtl/lab2_proc_pkg.sv
// Shared definitions for the RV32 pipelined processor decode stage.
// Holds the opcode constants, the immediate-type encoding (shared with the
// immediate generator), bypass-select encoding, operand-select constants and
// the decoded control bundle passed from the decode table to the D-stage
// controller.
package lab2_proc_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // addi x0, x0, 0
  localparam logic [31:0] INST_NOP = 32'h00000013;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_e;

  typedef enum logic [1:0] {
    BYP_RF = 2'd0,
    BYP_X  = 2'd1,
    BYP_M  = 2'd2,
    BYP_W  = 2'd3
  } byp_sel_e;

  localparam logic OP1_RS1 = 1'b0;
  localparam logic OP1_PC  = 1'b1;
  localparam logic OP2_RS2 = 1'b0;
  localparam logic OP2_IMM = 1'b1;

  typedef struct packed {
    imm_type_e imm_type;
    logic      op1_sel;
    logic      op2_sel;
    logic      wen;
    logic      reads_rs1;
    logic      reads_rs2;
    logic      illegal;
    logic      is_jal;
  } dec_ctrl_t;

endpackage

// File: rtl/lab2_proc_dstage_decode.sv
// Purely combinational opcode-to-control table for the decode stage.
// Ports:
//   opcode  in  7   inst[6:0] of the instruction held in D
//   ctrl    out     decoded controls (imm type, operand selects, rd write
//                   intent before the rd==0 gate, source usage, illegal, JAL)
module lab2_proc_dstage_decode
  import lab2_proc_pkg::*;
(
  input  logic [6:0] opcode,
  output dec_ctrl_t  ctrl
);

  always_comb begin
    ctrl          = '0;
    ctrl.imm_type = IMM_I;
    ctrl.op1_sel  = OP1_RS1;
    ctrl.op2_sel  = OP2_RS2;
    case (opcode)
      OPC_OP: begin
        ctrl.reads_rs1 = 1'b1;
        ctrl.reads_rs2 = 1'b1;
        ctrl.wen       = 1'b1;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        ctrl.reads_rs1 = 1'b1;
        ctrl.op2_sel   = OP2_IMM;
        ctrl.wen       = 1'b1;
      end
      OPC_STORE: begin
        ctrl.imm_type  = IMM_S;
        ctrl.reads_rs1 = 1'b1;
        ctrl.reads_rs2 = 1'b1;
        ctrl.op2_sel   = OP2_IMM;
      end
      OPC_BRANCH: begin
        ctrl.imm_type  = IMM_B;
        ctrl.reads_rs1 = 1'b1;
        ctrl.reads_rs2 = 1'b1;
      end
      OPC_LUI: begin
        ctrl.imm_type = IMM_U;
        ctrl.op2_sel  = OP2_IMM;
        ctrl.wen      = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.imm_type = IMM_U;
        ctrl.op1_sel  = OP1_PC;
        ctrl.op2_sel  = OP2_IMM;
        ctrl.wen      = 1'b1;
      end
      OPC_JAL: begin
        ctrl.imm_type = IMM_J;
        ctrl.op1_sel  = OP1_PC;
        ctrl.wen      = 1'b1;
        ctrl.is_jal   = 1'b1;
      end
      // Unsupported opcodes still flow to X, which raises the trap.
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/lab2_proc_dstage_ctrl.sv
// Decode-stage controller: F/D pipeline register, decode, load-use stall,
// X/M/W bypass selection and the F->D->X val/rdy handshake with squash and
// JAL redirect.
// Ports:
//   clk, reset (sync, active-low)
//   inst_F, val_F, rdy_D         fetch-side handshake
//   squash_D                     X-stage redirect, kills D and incoming F
//   rdy_X, val_X                 X-side handshake
//   inst_D, imm_type_D           registered instruction / imm-gen type
//   op1_sel_D, op2_sel_D         operand selects
//   rf_wen_D, illegal_D          register write, unsupported opcode
//   byp1_sel_D, byp2_sel_D       0=RF 1=X 2=M 3=W
//   squash_F                     JAL issued from D, F must redirect
//   rd_*/wen_* (X/M/W), load_X   downstream destination info
module lab2_proc_dstage_ctrl
  import lab2_proc_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              inst_F,
  input  logic                     val_F,
  output logic                     rdy_D,
  input  logic                     squash_D,
  input  logic                     rdy_X,
  output logic                     val_X,
  output logic [31:0]              inst_D,
  output logic [2:0]               imm_type_D,
  output logic                     op1_sel_D,
  output logic                     op2_sel_D,
  output logic                     rf_wen_D,
  output logic                     illegal_D,
  output logic [1:0]               byp1_sel_D,
  output logic [1:0]               byp2_sel_D,
  output logic                     squash_F,
  input  logic [$clog2(NREGS)-1:0] rd_X,
  input  logic [$clog2(NREGS)-1:0] rd_M,
  input  logic [$clog2(NREGS)-1:0] rd_W,
  input  logic                     wen_X,
  input  logic                     wen_M,
  input  logic                     wen_W,
  input  logic                     load_X
);

  localparam int RW = $clog2(NREGS);

  logic            val_D_reg;
  logic [31:0]     inst_D_reg;
  dec_ctrl_t       ctrl;
  logic [RW-1:0]   rs1, rs2, rd;
  logic            rs1_used, rs2_used;
  logic            stall_D, go_D;

  lab2_proc_dstage_decode u_decode (
    .opcode (inst_D_reg[6:0]),
    .ctrl   (ctrl)
  );

  function automatic byp_sel_e pick_byp(
    input logic          used,
    input logic [RW-1:0] rs,
    input logic          wx, input logic [RW-1:0] rx,
    input logic          wm, input logic [RW-1:0] rm,
    input logic          ww, input logic [RW-1:0] rw
  );
    if (!used)                 return BYP_RF;
    else if (wx && (rx == rs)) return BYP_X;
    else if (wm && (rm == rs)) return BYP_M;
    else if (ww && (rw == rs)) return BYP_W;
    else                       return BYP_RF;
  endfunction

  always_comb begin
    rs1 = inst_D_reg[19:15];
    rs2 = inst_D_reg[24:20];
    rd  = inst_D_reg[11:7];

    // x0 never creates a dependency.
    rs1_used = val_D_reg & ctrl.reads_rs1 & (rs1 != '0);
    rs2_used = val_D_reg & ctrl.reads_rs2 & (rs2 != '0);

    stall_D = val_D_reg & load_X & wen_X &
              ((rs1_used & (rs1 == rd_X)) | (rs2_used & (rs2 == rd_X)));

    val_X    = val_D_reg & ~stall_D & ~squash_D;
    go_D     = val_X & rdy_X;
    rdy_D    = ~val_D_reg | go_D;
    squash_F = go_D & ctrl.is_jal;

    inst_D     = inst_D_reg;
    imm_type_D = val_D_reg ? ctrl.imm_type : IMM_I;
    op1_sel_D  = val_D_reg & ctrl.op1_sel;
    op2_sel_D  = val_D_reg & ctrl.op2_sel;
    rf_wen_D   = val_D_reg & ctrl.wen & (rd != '0);
    illegal_D  = val_D_reg & ctrl.illegal;
    byp1_sel_D = pick_byp(rs1_used, rs1, wen_X, rd_X, wen_M, rd_M, wen_W, rd_W);
    byp2_sel_D = pick_byp(rs2_used, rs2, wen_X, rd_X, wen_M, rd_M, wen_W, rd_W);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      val_D_reg  <= 1'b0;
      inst_D_reg <= INST_NOP;
    end else if (squash_D) begin
      val_D_reg <= 1'b0;
    end else if (squash_F) begin
      // The instruction behind a JAL is on the wrong path.
      val_D_reg <= 1'b0;
    end else if (val_F && rdy_D) begin
      val_D_reg  <= 1'b1;
      inst_D_reg <= inst_F;
    end else if (go_D) begin
      val_D_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lab2_proc_dstage_ctrl.sv
module tb_lab2_proc_dstage_ctrl;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] ADD  = 32'h00108133;
  localparam logic [31:0] JAL  = 32'h008000EF;
  localparam logic [31:0] ILL  = 32'h000000F3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst_F;
  logic        val_F, rdy_D, squash_D, rdy_X, val_X;
  logic [31:0] inst_D;
  logic [2:0]  imm_type_D;
  logic        op1_sel_D, op2_sel_D, rf_wen_D, illegal_D, squash_F;
  logic [1:0]  byp1_sel_D, byp2_sel_D;
  logic [4:0]  rd_X, rd_M, rd_W;
  logic        wen_X, wen_M, wen_W, load_X;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lab2_proc_dstage_ctrl dut (
    .clk(clk), .reset(reset), .inst_F(inst_F), .val_F(val_F), .rdy_D(rdy_D),
    .squash_D(squash_D), .rdy_X(rdy_X), .val_X(val_X), .inst_D(inst_D),
    .imm_type_D(imm_type_D), .op1_sel_D(op1_sel_D), .op2_sel_D(op2_sel_D),
    .rf_wen_D(rf_wen_D), .illegal_D(illegal_D), .byp1_sel_D(byp1_sel_D),
    .byp2_sel_D(byp2_sel_D), .squash_F(squash_F), .rd_X(rd_X), .rd_M(rd_M),
    .rd_W(rd_W), .wen_X(wen_X), .wen_M(wen_M), .wen_W(wen_W), .load_X(load_X)
  );

  // Reference decode: instruction format and register usage per opcode.
  typedef struct packed {
    logic [2:0] it;
    logic o1, o2, w, r1, r2, ill;
  } exp_t;

  function automatic exp_t ref_decode(input logic [6:0] opc);
    exp_t e;
    e = '0;
    case (opc)
      7'h33: begin e.r1 = 1; e.r2 = 1; e.w = 1; end
      7'h13, 7'h03, 7'h67: begin e.r1 = 1; e.o2 = 1; e.w = 1; end
      7'h23: begin e.it = 3'd1; e.r1 = 1; e.r2 = 1; e.o2 = 1; end
      7'h63: begin e.it = 3'd2; e.r1 = 1; e.r2 = 1; end
      7'h37: begin e.it = 3'd3; e.o2 = 1; e.w = 1; end
      7'h17: begin e.it = 3'd3; e.o1 = 1; e.o2 = 1; e.w = 1; end
      7'h6F: begin e.it = 3'd4; e.o1 = 1; e.w = 1; end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  task automatic idle_inputs();
    val_F = 0; inst_F = 32'h0; squash_D = 0; rdy_X = 1;
    rd_X = 0; rd_M = 0; rd_W = 0; wen_X = 0; wen_M = 0; wen_W = 0; load_X = 0;
  endtask

  task automatic empty_d();
    @(negedge clk); idle_inputs(); squash_D = 1;
    @(posedge clk);
  endtask

  task automatic load_d(input logic [31:0] inst);
    @(negedge clk); idle_inputs(); val_F = 1; inst_F = inst;
    @(posedge clk);
  endtask

  task automatic test_reset();
    idle_inputs(); reset = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1; #1;
    vectors++; if (val_X !== 1'b0) begin miscompares++; $display("FAIL reset_val_X: got %0d want 0", val_X); end
    vectors++; if (rdy_D !== 1'b1) begin miscompares++; $display("FAIL reset_rdy_D: got %0d want 1", rdy_D); end
    vectors++; if (inst_D !== NOP) begin miscompares++; $display("FAIL reset_inst_D: got %h want %h", inst_D, NOP); end
    vectors++; if ({imm_type_D, op1_sel_D, op2_sel_D, rf_wen_D, illegal_D, byp1_sel_D, byp2_sel_D, squash_F} !== 12'h0) begin
      miscompares++; $display("FAIL reset_outputs_zero: got %h want 0",
        {imm_type_D, op1_sel_D, op2_sel_D, rf_wen_D, illegal_D, byp1_sel_D, byp2_sel_D, squash_F}); end
  endtask

  task automatic test_bypass();
    empty_d();
    load_d(ADDI);
    @(negedge clk); val_F = 1; inst_F = ADD; #1;
    vectors++; if (val_X !== 1'b1) begin miscompares++; $display("FAIL byp_addi_val_X: got %0d want 1", val_X); end
    vectors++; if (imm_type_D !== 3'd0) begin miscompares++; $display("FAIL byp_addi_imm: got %0d want 0", imm_type_D); end
    vectors++; if ({op2_sel_D, rf_wen_D} !== 2'b11) begin miscompares++; $display("FAIL byp_addi_ctrl: got %b want 11", {op2_sel_D, rf_wen_D}); end
    vectors++; if (rdy_D !== 1'b1) begin miscompares++; $display("FAIL byp_addi_rdy_D: got %0d want 1", rdy_D); end
    @(posedge clk);
    @(negedge clk); val_F = 0; wen_X = 1; rd_X = 1; wen_M = 1; rd_M = 1; #1;
    vectors++; if (inst_D !== ADD) begin miscompares++; $display("FAIL byp_add_inst_D: got %h want %h", inst_D, ADD); end
    vectors++; if ({byp1_sel_D, byp2_sel_D} !== 4'b0101) begin miscompares++; $display("FAIL byp_add_sel_X: got %b want 0101", {byp1_sel_D, byp2_sel_D}); end
    vectors++; if ({val_X, op2_sel_D} !== 2'b10) begin miscompares++; $display("FAIL byp_add_valx_op2: got %b want 10", {val_X, op2_sel_D}); end
    @(posedge clk);
    @(negedge clk); idle_inputs(); #1;
    vectors++; if ({val_X, rdy_D} !== 2'b01) begin miscompares++; $display("FAIL byp_drain: got %b want 01", {val_X, rdy_D}); end
  endtask

  task automatic test_load_use();
    empty_d();
    load_d(ADD);
    @(negedge clk); val_F = 1; inst_F = ADDI; load_X = 1; wen_X = 1; rd_X = 1; #1;
    vectors++; if ({val_X, rdy_D} !== 2'b00) begin miscompares++; $display("FAIL lu_stall: got %b want 00", {val_X, rdy_D}); end
    @(posedge clk);
    @(negedge clk); #1;
    vectors++; if (inst_D !== ADD) begin miscompares++; $display("FAIL lu_hold_inst: got %h want %h", inst_D, ADD); end
    @(negedge clk); val_F = 0; load_X = 0; wen_X = 0; wen_M = 1; rd_M = 1; wen_W = 1; rd_W = 1; #1;
    vectors++; if ({byp1_sel_D, byp2_sel_D} !== 4'b1010) begin miscompares++; $display("FAIL lu_byp_M: got %b want 1010", {byp1_sel_D, byp2_sel_D}); end
    vectors++; if ({val_X, rdy_D} !== 2'b11) begin miscompares++; $display("FAIL lu_issue: got %b want 11", {val_X, rdy_D}); end
    // Reset asserted while stalled clears D.
    load_d(ADD);
    @(negedge clk); val_F = 1; inst_F = ADDI; load_X = 1; wen_X = 1; rd_X = 1; squash_D = 0; reset = 0;
    @(posedge clk);
    @(negedge clk); reset = 1; idle_inputs(); #1;
    vectors++; if ({val_X, rdy_D} !== 2'b01 || inst_D !== NOP) begin miscompares++; $display("FAIL lu_reset_mid_stall: got val_X=%0d rdy_D=%0d inst=%h want 0 1 %h", val_X, rdy_D, inst_D, NOP); end
    // Squash during a stall wins.
    load_d(ADD);
    @(negedge clk); load_X = 1; wen_X = 1; rd_X = 1; squash_D = 1; val_F = 1; inst_F = ADDI;
    @(posedge clk);
    @(negedge clk); idle_inputs(); #1;
    vectors++; if ({val_X, rdy_D} !== 2'b01 || inst_D !== ADD) begin miscompares++; $display("FAIL lu_squash_stall: got val_X=%0d rdy_D=%0d inst=%h want 0 1 %h", val_X, rdy_D, inst_D, ADD); end
  endtask

  task automatic test_jal();
    empty_d();
    load_d(JAL);
    @(negedge clk); val_F = 1; inst_F = ADDI; rdy_X = 0; #1;
    vectors++; if (squash_F !== 1'b0) begin miscompares++; $display("FAIL jal_no_go_squash_F: got %0d want 0", squash_F); end
    @(posedge clk);
    @(negedge clk); rdy_X = 1; #1;
    vectors++; if (squash_F !== 1'b1) begin miscompares++; $display("FAIL jal_squash_F: got %0d want 1", squash_F); end
    vectors++; if ({imm_type_D, op1_sel_D, rf_wen_D, val_X} !== 6'b100111) begin miscompares++; $display("FAIL jal_ctrl: got %b want 100111", {imm_type_D, op1_sel_D, rf_wen_D, val_X}); end
    @(posedge clk);
    @(negedge clk); idle_inputs(); #1;
    vectors++; if ({val_X, squash_F} !== 2'b00) begin miscompares++; $display("FAIL jal_after: got %b want 00", {val_X, squash_F}); end
  endtask

  task automatic test_squash();
    empty_d();
    load_d(ADDI);
    @(negedge clk); rdy_X = 0; squash_D = 1; val_F = 1; inst_F = ADD; #1;
    vectors++; if ({val_X, rdy_D} !== 2'b00) begin miscompares++; $display("FAIL sq_same_cycle: got %b want 00", {val_X, rdy_D}); end
    @(posedge clk);
    @(negedge clk); idle_inputs(); #1;
    vectors++; if ({val_X, rdy_D} !== 2'b01 || inst_D !== ADDI) begin miscompares++; $display("FAIL sq_not_latched: got val_X=%0d rdy_D=%0d inst=%h want 0 1 %h", val_X, rdy_D, inst_D, ADDI); end
  endtask

  task automatic test_illegal();
    empty_d();
    load_d(ILL);
    @(negedge clk); #1;
    vectors++; if ({illegal_D, rf_wen_D, val_X} !== 3'b101) begin miscompares++; $display("FAIL ill_ctrl: got %b want 101", {illegal_D, rf_wen_D, val_X}); end
    vectors++; if (imm_type_D !== 3'd0) begin miscompares++; $display("FAIL ill_imm: got %0d want 0", imm_type_D); end
  endtask

  function automatic logic [1:0] ref_byp(input logic used, input logic [4:0] rs);
    if (!used) return 2'd0;
    if (wen_X && rd_X == rs) return 2'd1;
    if (wen_M && rd_M == rs) return 2'd2;
    if (wen_W && rd_W == rs) return 2'd3;
    return 2'd0;
  endfunction

  task automatic test_random();
    logic        m_val;
    logic [31:0] m_inst;
    logic [6:0]  opcs [10];
    exp_t        e;
    logic        u1, u2, e_stall, e_valx, e_go, e_rdy, e_sqf, e_wen;
    logic [4:0]  rs1, rs2, rd;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h73};
    empty_d();
    m_val = 0; m_inst = inst_D;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset    = ($urandom_range(0, 63) != 0);
      val_F    = $urandom_range(0, 3) != 0;
      inst_F   = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  3'($urandom), 5'($urandom_range(0, 3)), opcs[$urandom_range(0, 9)]};
      squash_D = $urandom_range(0, 15) == 0;
      rdy_X    = $urandom_range(0, 3) != 0;
      rd_X = 5'($urandom_range(0, 3)); rd_M = 5'($urandom_range(0, 3)); rd_W = 5'($urandom_range(0, 3));
      wen_X = 1'($urandom); wen_M = 1'($urandom); wen_W = 1'($urandom);
      load_X = 1'($urandom);
      #1;
      e   = ref_decode(m_inst[6:0]);
      rs1 = m_inst[19:15]; rs2 = m_inst[24:20]; rd = m_inst[11:7];
      u1  = m_val && e.r1 && rs1 != 0;
      u2  = m_val && e.r2 && rs2 != 0;
      e_stall = m_val && load_X && wen_X && ((u1 && rs1 == rd_X) || (u2 && rs2 == rd_X));
      e_valx  = m_val && !e_stall && !squash_D;
      e_go    = e_valx && rdy_X;
      e_rdy   = !m_val || e_go;
      e_sqf   = e_go && m_inst[6:0] == 7'h6F;
      e_wen   = m_val && e.w && rd != 0;
      vectors++; if (inst_D !== m_inst) begin miscompares++; $display("FAIL rnd_inst_D n=%0d: got %h want %h", n, inst_D, m_inst); end
      vectors++; if ({val_X, rdy_D, squash_F} !== {e_valx, e_rdy, e_sqf}) begin miscompares++;
        $display("FAIL rnd_handshake n=%0d: got %b want %b", n, {val_X, rdy_D, squash_F}, {e_valx, e_rdy, e_sqf}); end
      vectors++; if ({imm_type_D, op1_sel_D, op2_sel_D, rf_wen_D, illegal_D} !==
                     (m_val ? {e.it, e.o1, e.o2, e_wen, e.ill} : 7'h0)) begin miscompares++;
        $display("FAIL rnd_decode n=%0d inst=%h: got %b want %b", n, m_inst,
          {imm_type_D, op1_sel_D, op2_sel_D, rf_wen_D, illegal_D}, (m_val ? {e.it, e.o1, e.o2, e_wen, e.ill} : 7'h0)); end
      if (!e_stall) begin
        vectors++; if ({byp1_sel_D, byp2_sel_D} !== {ref_byp(u1, rs1), ref_byp(u2, rs2)}) begin miscompares++;
          $display("FAIL rnd_bypass n=%0d: got %b want %b", n, {byp1_sel_D, byp2_sel_D}, {ref_byp(u1, rs1), ref_byp(u2, rs2)}); end
      end
      @(posedge clk);
      if (!reset) begin m_val = 0; m_inst = NOP; end
      else if (squash_D) m_val = 0;
      else if (e_sqf) m_val = 0;
      else if (val_F && e_rdy) begin m_val = 1; m_inst = inst_F; end
      else if (e_go) m_val = 0;
    end
    @(negedge clk); reset = 1; idle_inputs();
  endtask

  initial begin
    reset = 1; idle_inputs();
    test_reset();
    test_bypass();
    test_load_use();
    test_jal();
    test_squash();
    test_illegal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lab2_proc_dstage_ctrl.md
Name: lab2_proc_dstage_ctrl

Overview:
Decode-stage controller for the pipelined RV32 processor. It holds the F/D pipeline register and decodes the opcode into the imm-gen type select, operand selects and register-write control. It detects load-use hazards and produces X/M/W bypass selects, and sequences the val/rdy handshakes between F and X, including squash and the JAL redirect. It sits between the fetch unit and the X stage and drives the immediate generator's imm_type input directly.

Parameters:
NREGS, 32, architectural register count; rd/rs fields are clog2(NREGS)=5 bits.

Ports:
clk  in  1  clock, all state updates on the rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
inst_F  in  32  instruction from fetch
val_F  in  1  inst_F valid
rdy_D  out  1  D can accept inst_F this cycle
squash_D  in  1  X-stage redirect; kills D contents and the incoming F instruction
rdy_X  in  1  X stage accepts
val_X  out  1  D presents a valid decoded instruction to X
inst_D  out  32  registered instruction, feeds imm gen and X
imm_type_D  out  3  0=I, 1=S, 2=B, 3=U, 4=J
op1_sel_D  out  1  0=rs1, 1=pc
op2_sel_D  out  1  0=rs2, 1=imm
rf_wen_D  out  1  instruction writes rd (rd!=0)
illegal_D  out  1  unsupported opcode
byp1_sel_D, byp2_sel_D  out  2 each  0=RF, 1=X, 2=M, 3=W
squash_F  out  1  JAL in D fired; F must drop its instruction and redirect
rd_X, rd_M, rd_W  in  5 each  destination registers of downstream stages
wen_X, wen_M, wen_W  in  1 each  downstream writes valid (already gated by val)
load_X  in  1  X holds a load

Behaviour:
- Reset (reset==0 at an edge): val_D_reg=0, inst_D_reg=32'h00000013 (NOP). While val_D_reg=0, all outputs are 0 except rdy_D=1.
- Decode uses opcode inst_D[6:0]:
  - OP: rs1+rs2, op2=rs2, wen=1.
  - OP-IMM: I, rs1, op2=imm, wen=1.
  - LOAD: I, rs1, op2=imm, wen=1.
  - STORE: S, rs1+rs2, op2=imm, wen=0.
  - BRANCH: B, rs1+rs2, op2=rs2, wen=0.
  - LUI: U, op2=imm, wen=1.
  - AUIPC: U, op1=pc, op2=imm, wen=1.
  - JAL: J, op1=pc, wen=1.
  - JALR: I, rs1, op2=imm, wen=1.
  - Any other opcode: illegal_D=1, imm_type=0, wen=0. The instruction still flows to X, which traps.
- rf_wen_D is forced to 0 when rd==0.
- A source register counts as used only if the opcode reads it and the field is nonzero.
- Load-use stall: stall_D = val_D & load_X & wen_X & used source == rd_X.
- Bypass per source: priority X > M > W, matching on wen_s & rd_s==rs. Otherwise the select is 0 (RF). Bypass selects are don't-care while stall_D=1.
- val_X = val_D & ~stall_D & ~squash_D.
- go_D = val_X & rdy_X.
- rdy_D = ~val_D | go_D.
- Next state, first matching rule wins:
  1. squash_D: val_D_reg<=0, and inst_F is ignored even if val_F=1.
  2. go_D with JAL: squash_F=1 (combinational, same cycle) and val_D_reg<=0; inst_F is discarded.
  3. val_F & rdy_D: load inst_F, val_D_reg<=1.
  4. go_D with no new instruction: val_D_reg<=0.
  5. Otherwise hold. Stall and rdy_X=0 both hold D and keep inst_D stable.
- Latency: an instruction accepted at edge n is presented to X in cycle n+1 when there is no stall. Throughput is 1 instruction per cycle.
- Simultaneous squash_D and a stall: squash wins and D is cleared.
- Asserting reset mid-stall clears D on the next edge, regardless of other inputs.

Decomposition:
- Package lab2_proc_pkg holds:
  - opcode localparams;
  - the imm_type enum (shared with the immediate generator; values exactly as above);
  - the bypass-select enum;
  - op1/op2 select constants.
- One sub-module, lab2_proc_dstage_decode: a purely combinational opcode-to-control table.
- Hazard, bypass and handshake logic stay in the top module.

Test Plan:
1. Reset low for 2 cycles, then high, val_F=0 → val_X=0, rdy_D=1, inst_D=32'h00000013.
2. Stream 32'h00500093 (addi x1,x0,5) then 32'h00108133 (add x2,x1,x1), with wen_X=1, rd_X=1, load_X=0 at decode of add → byp1_sel=byp2_sel=1, imm_type=0 for addi, val_X=1 each cycle.
3. Decode of add x2,x1,x1 with load_X=1, rd_X=1, wen_X=1 → val_X=0, rdy_D=0, inst_D held. Then load_X=0 with wen_M=1, rd_M=1 → byp sels=2, instruction issues.
4. D holds JAL 32'h008000EF, rdy_X=1, val_F=1 → squash_F=1 for one cycle, imm_type=4, next cycle val_X=0.
5. D holds a valid instruction, rdy_X=0, squash_D=1, val_F=1 → next cycle val_D_reg=0 and the F instruction is not latched.
6. Opcode 7'b1110011 → illegal_D=1, rf_wen_D=0, val_X=1.
